// File: rtl/iprd_freelist_pkg.sv
// iprd_freelist_pkg
//   Shared backend definitions for the integer physical-register freelist:
//   default lane counts, register-file sizes, the freelist depth, the
//   physical register index type, the freelist pointer type and the
//   freelist recovery state encoding.
//   No ports (package).
package iprd_freelist_pkg;

    localparam int DEF_RENAME_WIDTH = 4;
    localparam int DEF_COMMIT_WIDTH = 4;
    localparam int DEF_IPRNUM       = 64;
    localparam int DEF_ILRNUM       = 32;

    // Freelist holds every physical register not backing a logical one.
    // Must be a power of two so pointers wrap naturally modulo 2*FLSIZE.
    localparam int FLSIZE    = DEF_IPRNUM - DEF_ILRNUM;
    localparam int IPR_IDX_W = $clog2(DEF_IPRNUM);
    localparam int FL_IDX_W  = $clog2(FLSIZE);
    localparam int FL_PTR_W  = FL_IDX_W + 1;      // index bits + wrap bit
    localparam int FL_CNT_W  = $clog2(FLSIZE + 1);

    typedef logic [IPR_IDX_W-1:0] ipr_idx_t;
    typedef logic [FL_PTR_W-1:0]  fl_ptr_t;

    typedef enum logic {
        FL_NORMAL  = 1'b0,
        FL_RECOVER = 1'b1
    } fl_state_t;

endpackage

// File: rtl/iprd_freelist_count_ones.sv
// count_ones
//   Population count of a lane vector plus, for every lane, the exclusive
//   prefix count (number of set bits strictly below that lane). Used to
//   pack active lanes onto consecutive freelist slots.
//   Ports:
//     bits   in  N        lane flags
//     total  out CW       number of set bits
//     prefix out N x CW   prefix[i] = popcount(bits[i-1:0])
module count_ones #(
    parameter int N  = 4,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]         bits,
    output logic [CW-1:0]        total,
    output logic [N-1:0][CW-1:0] prefix
);

    logic [CW-1:0] acc;

    always_comb begin
        acc    = '0;
        prefix = '0;
        for (int i = 0; i < N; i++) begin
            prefix[i] = acc;
            acc       = acc + CW'(bits[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/iprd_freelist.sv
// iprd_freelist
//   Circular freelist of integer physical register indices for rename.
//   Allocation pops from spec_head, commit releases push previous mappings
//   at tail, arch_head tracks allocations that have committed so a squash
//   can roll spec_head back. A one-cycle RECOVER state blocks allocation
//   right after a squash.
//
//   Allocation handshake: o_can_alloc acts as ready and (i_alloc_en with any
//   i_alloc_req bit) as valid; entries are consumed only on a cycle where
//   o_can_alloc & i_alloc_en & !i_squash_vld is high, and o_alloc_iprd is
//   stable for the whole cycle. Commit lanes have no backpressure: every
//   i_commit_vld lane is accepted on the clock edge.
//
//   Ports:
//     clk, rst             clock, asynchronous active-high reset
//     i_alloc_req          per-lane request for a new physical register
//     i_alloc_en           rename stage advances this cycle
//     o_can_alloc          enough free entries for all requesting lanes
//     o_alloc_iprd         per-lane allocated index (packed by request order)
//     i_commit_vld         per-lane commit that releases a previous mapping
//     i_commit_prev_iprd   per-lane released physical index
//     i_squash_vld         pipeline squash, rolls spec_head back
//     o_free_count         speculative free-entry count
//     dbg_state            current NORMAL/RECOVER state
module iprd_freelist
    import iprd_freelist_pkg::*;
#(
    parameter int RENAME_WIDTH = DEF_RENAME_WIDTH,
    parameter int COMMIT_WIDTH = DEF_COMMIT_WIDTH,
    parameter int IPRNUM       = DEF_IPRNUM,
    parameter int ILRNUM       = DEF_ILRNUM
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic     [RENAME_WIDTH-1:0]       i_alloc_req,
    input  logic                              i_alloc_en,
    output logic                              o_can_alloc,
    output ipr_idx_t [RENAME_WIDTH-1:0]       o_alloc_iprd,
    input  logic     [COMMIT_WIDTH-1:0]       i_commit_vld,
    input  ipr_idx_t [COMMIT_WIDTH-1:0]       i_commit_prev_iprd,
    input  logic                              i_squash_vld,
    output logic     [FL_CNT_W-1:0]           o_free_count,
    output fl_state_t                         dbg_state
);

    localparam int ACW = $clog2(RENAME_WIDTH + 1);
    localparam int CCW = $clog2(COMMIT_WIDTH + 1);

    ipr_idx_t  entry_q [FLSIZE];
    fl_ptr_t   spec_head_q, arch_head_q, tail_q;
    fl_ptr_t   spec_head_nxt, arch_head_nxt, tail_nxt;
    fl_state_t state_q;

    logic [ACW-1:0]                   alloc_total;
    logic [RENAME_WIDTH-1:0][ACW-1:0] alloc_prefix;
    logic [CCW-1:0]                   commit_total;
    logic [COMMIT_WIDTH-1:0][CCW-1:0] commit_prefix;

    fl_ptr_t alloc_rd_ptr  [RENAME_WIDTH];
    fl_ptr_t commit_wr_ptr [COMMIT_WIDTH];
    fl_ptr_t free_diff;
    logic    alloc_fire;

    count_ones #(.N(RENAME_WIDTH), .CW(ACW)) u_alloc_cnt (
        .bits   (i_alloc_req),
        .total  (alloc_total),
        .prefix (alloc_prefix)
    );

    count_ones #(.N(COMMIT_WIDTH), .CW(CCW)) u_commit_cnt (
        .bits   (i_commit_vld),
        .total  (commit_total),
        .prefix (commit_prefix)
    );

    // Pointer difference is taken with the wrap bit, so full (FLSIZE) and
    // empty (0) are distinguishable.
    assign free_diff    = tail_q - spec_head_q;
    assign o_free_count = FL_CNT_W'(free_diff);
    assign o_can_alloc  = (state_q == FL_NORMAL) &&
                          (FL_CNT_W'(alloc_total) <= o_free_count);
    assign alloc_fire   = o_can_alloc & i_alloc_en & ~i_squash_vld;
    assign dbg_state    = state_q;

    // Every lane reads the slot it would get, requesting or not; the
    // renamer simply ignores lanes without a request.
    always_comb begin
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            alloc_rd_ptr[i] = spec_head_q + fl_ptr_t'(alloc_prefix[i]);
            o_alloc_iprd[i] = entry_q[alloc_rd_ptr[i][FL_IDX_W-1:0]];
        end
    end

    always_comb begin
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            commit_wr_ptr[j] = tail_q + fl_ptr_t'(commit_prefix[j]);
        end
    end

    // A squash restores spec_head to the committed position including this
    // cycle's commits, which is exactly arch_head_nxt.
    always_comb begin
        arch_head_nxt = arch_head_q + fl_ptr_t'(commit_total);
        tail_nxt      = tail_q + fl_ptr_t'(commit_total);
        spec_head_nxt = spec_head_q;
        if (i_squash_vld) begin
            spec_head_nxt = arch_head_nxt;
        end else if (alloc_fire) begin
            spec_head_nxt = spec_head_q + fl_ptr_t'(alloc_total);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < FLSIZE; k++) begin
                entry_q[k] <= ipr_idx_t'(ILRNUM + k);
            end
            spec_head_q <= '0;
            arch_head_q <= '0;
            tail_q      <= fl_ptr_t'(FLSIZE);
            state_q     <= FL_NORMAL;
        end else begin
            for (int j = 0; j < COMMIT_WIDTH; j++) begin
                if (i_commit_vld[j]) begin
                    entry_q[commit_wr_ptr[j][FL_IDX_W-1:0]] <= i_commit_prev_iprd[j];
                end
            end
            spec_head_q <= spec_head_nxt;
            arch_head_q <= arch_head_nxt;
            tail_q      <= tail_nxt;
            case (state_q)
                FL_NORMAL:  state_q <= i_squash_vld ? FL_RECOVER : FL_NORMAL;
                FL_RECOVER: state_q <= i_squash_vld ? FL_RECOVER : FL_NORMAL;
                default:    state_q <= FL_NORMAL;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Illegal releases: more entries than the freelist can hold, index 0
    // (hard-wired zero register) or an index outside the register file.
    always @(posedge clk) begin
        if (!rst) begin
            assert (int'(o_free_count) + int'(commit_total) <= FLSIZE)
                else $error("iprd_freelist: release overflows freelist");
            for (int j = 0; j < COMMIT_WIDTH; j++) begin
                if (i_commit_vld[j]) begin
                    assert (i_commit_prev_iprd[j] != '0 &&
                            int'(i_commit_prev_iprd[j]) < IPRNUM)
                        else $error("iprd_freelist: illegal release index on lane %0d", j);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_iprd_freelist.sv
// tb_iprd_freelist
//   Directed checks of reset, packing, full/empty, squash recovery and
//   asynchronous reset, followed by a randomized alloc/commit phase checked
//   against a FIFO model of the freelist contents.
module tb_iprd_freelist;
    import iprd_freelist_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic     [3:0]        alloc_req;
    logic                  alloc_en;
    logic                  can_alloc;
    ipr_idx_t [3:0]        alloc_iprd;
    logic     [3:0]        commit_vld;
    ipr_idx_t [3:0]        commit_prev;
    logic                  squash;
    logic     [5:0]        free_count;
    fl_state_t             state;

    int n_checks = 0;
    int n_errors = 0;

    // Freelist model: front is the next index to be allocated.
    logic [5:0] exp_q[$];
    // Previous mappings awaiting commit, in program order.
    logic [5:0] rob_q[$];
    bit         busy[64];
    logic [5:0] spec_map[32];

    iprd_freelist dut (
        .clk                (clk),
        .rst                (rst),
        .i_alloc_req        (alloc_req),
        .i_alloc_en         (alloc_en),
        .o_can_alloc        (can_alloc),
        .o_alloc_iprd       (alloc_iprd),
        .i_commit_vld       (commit_vld),
        .i_commit_prev_iprd (commit_prev),
        .i_squash_vld       (squash),
        .o_free_count       (free_count),
        .dbg_state          (state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic drive_idle();
        alloc_req   = '0;
        alloc_en    = 1'b0;
        commit_vld  = '0;
        commit_prev = '0;
        squash      = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change at negedge, outputs are sampled 1ns later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] vld;
        int         nc;
        int         k;
        logic       exp_can;
        logic [5:0] x;
        logic [5:0] p;

        rst = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // ---- reset state and packed allocation 4'b1011 ----
        alloc_req = 4'b1011;
        alloc_en  = 1'b1;
        #1;
        check("reset_free", free_count, 32);
        check("reset_can", can_alloc, 1);
        check("reset_state", state, FL_NORMAL);
        check("alloc_lane0", alloc_iprd[0], 32);
        check("alloc_lane1", alloc_iprd[1], 33);
        check("alloc_lane2_idle", alloc_iprd[2], 34);
        check("alloc_lane3", alloc_iprd[3], 34);
        next_cycle();
        drive_idle();
        #1;
        check("after3_free", free_count, 29);
        check("after3_head", alloc_iprd[0], 35);

        // ---- drain to empty, then one more request must stall ----
        do_reset();
        for (int c = 0; c < 8; c++) begin
            alloc_req = 4'b1111;
            alloc_en  = 1'b1;
            next_cycle();
        end
        alloc_req = 4'b0001;
        alloc_en  = 1'b1;
        #1;
        check("empty_free", free_count, 0);
        check("empty_can", can_alloc, 0);
        check("empty_head", alloc_iprd[0], 32);
        next_cycle();
        #1;
        check("stall_free", free_count, 0);
        check("stall_head", alloc_iprd[0], 32);

        // ---- release 5 and 7 on sparse lanes 0 and 2 into empty list ----
        alloc_req      = '0;
        alloc_en       = 1'b0;
        commit_vld     = 4'b0101;
        commit_prev[0] = 6'd5;
        commit_prev[1] = 6'd63;
        commit_prev[2] = 6'd7;
        commit_prev[3] = 6'd62;
        next_cycle();
        drive_idle();
        alloc_req = 4'b0011;
        #1;
        check("refill_free", free_count, 2);
        check("refill_can", can_alloc, 1);
        check("refill_lane0", alloc_iprd[0], 5);
        check("refill_lane1", alloc_iprd[1], 7);

        // ---- allocate 12, then commit 4 with squash in the same cycle ----
        do_reset();
        for (int c = 0; c < 3; c++) begin
            alloc_req = 4'b1111;
            alloc_en  = 1'b1;
            next_cycle();
        end
        #1;
        check("spec12_free", free_count, 20);
        commit_vld = 4'b1111;
        for (int j = 0; j < 4; j++) commit_prev[j] = 6'(j + 1);
        squash = 1'b1;
        #1;
        check("squash_cyc_can", can_alloc, 1);
        next_cycle();
        drive_idle();
        alloc_req = 4'b0001;
        alloc_en  = 1'b1;
        #1;
        // tail 32+4=36, arch_head 0+4=4, spec_head restored to 4
        check("recover_state", state, FL_RECOVER);
        check("recover_can", can_alloc, 0);
        check("recover_free", free_count, 32);
        check("recover_head", alloc_iprd[0], 36);
        next_cycle();
        #1;
        check("post_rec_state", state, FL_NORMAL);
        check("post_rec_can", can_alloc, 1);
        check("post_rec_free", free_count, 32);
        check("post_rec_head", alloc_iprd[0], 36);
        drive_idle();

        // ---- asynchronous reset while in RECOVER ----
        do_reset();
        alloc_req = 4'b1111;
        alloc_en  = 1'b1;
        next_cycle();
        drive_idle();
        commit_vld     = 4'b0011;
        commit_prev[0] = 6'd9;
        commit_prev[1] = 6'd10;
        squash         = 1'b1;
        next_cycle();
        drive_idle();
        alloc_req = 4'b1011;
        #1;
        check("pre_rst_state", state, FL_RECOVER);
        check("pre_rst_head", alloc_iprd[0], 34);
        #1;
        rst = 1'b1;
        #1;
        check("arst_state", state, FL_NORMAL);
        check("arst_can", can_alloc, 1);
        check("arst_free", free_count, 32);
        check("arst_lane0", alloc_iprd[0], 32);
        check("arst_lane3", alloc_iprd[3], 34);
        next_cycle();
        rst = 1'b0;
        drive_idle();

        // ---- randomized alloc/commit against FIFO model ----
        do_reset();
        exp_q.delete();
        rob_q.delete();
        for (int i = 0; i < 64; i++) begin
            busy[i] = (i < 32);
            if (i >= 32) exp_q.push_back(6'(i));
        end
        for (int i = 0; i < 32; i++) spec_map[i] = 6'(i);

        for (int c = 0; c < 200; c++) begin
            alloc_req = 4'($urandom_range(0, 15));
            alloc_en  = ($urandom_range(0, 7) != 0);
            vld       = 4'($urandom_range(0, 15));
            nc        = 0;
            for (int i = 0; i < 4; i++) begin
                commit_prev[i] = '0;
                if (vld[i]) begin
                    if (nc < rob_q.size()) begin
                        commit_prev[i] = rob_q[nc];
                        nc++;
                    end else begin
                        vld[i] = 1'b0;
                    end
                end
            end
            commit_vld = vld;
            #1;
            exp_can = ($countones(alloc_req) <= exp_q.size());
            check("rnd_free", free_count, exp_q.size());
            check("rnd_can", can_alloc, exp_can);
            k = 0;
            for (int i = 0; i < 4; i++) begin
                if (alloc_req[i]) begin
                    if (k < exp_q.size()) check("rnd_iprd", alloc_iprd[i], exp_q[k]);
                    if (exp_can && alloc_en) check("rnd_unique", busy[alloc_iprd[i]], 0);
                    k++;
                end
            end
            if (exp_can && alloc_en) begin
                for (int i = 0; i < k; i++) begin
                    x = exp_q.pop_front();
                    busy[x] = 1'b1;
                    p = 6'($urandom_range(1, 31));
                    rob_q.push_back(spec_map[p[4:0]]);
                    spec_map[p[4:0]] = x;
                end
            end
            for (int i = 0; i < nc; i++) begin
                x = rob_q.pop_front();
                busy[x] = 1'b0;
                exp_q.push_back(x);
            end
            next_cycle();
        end
        drive_idle();
        #1;
        check("final_free", free_count, exp_q.size());

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
